// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: control-field widths, M-field bit
// positions, issue FSM state encoding and bubble constants.
package pipe_ctrl_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 2;
  localparam int EX_W = 4;

  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } issue_state_e;

  localparam logic [WB_W-1:0] WB_BUBBLE = '0;
  localparam logic [M_W-1:0]  M_BUBBLE  = '0;
  localparam logic [EX_W-1:0] EX_BUBBLE = '0;

endpackage

// File: rtl/lu_hazard_cmp.sv
// Load-use hazard comparator: the load in ID/EX targets a register that the
// instruction in ID actually reads. Register 0 never creates a dependency.
module lu_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [M_W-1:0] ex_m,
  input  logic [4:0]     ex_rt,
  input  logic [4:0]     id_rs,
  input  logic [4:0]     id_rt,
  input  logic           id_uses_rs,
  input  logic           id_uses_rt,
  output logic           lu_hit
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (id_rs == ex_rt);
  assign rt_match = id_uses_rt && (id_rt == ex_rt);
  assign lu_hit   = ex_m[M_MEMREAD] && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: load-use stalls, branch-redirect flushes and
// bubble insertion into ID/EX. Define ISSUE_PERF_EN for stall/flush counters.
module id_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_EXTRA_STALL = 0,
  parameter int CNT_W            = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WB_W-1:0] id_wb,
  input  logic [M_W-1:0]  id_m,
  input  logic [EX_W-1:0] id_ex,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [M_W-1:0]  ex_m,
  input  logic [4:0]      ex_rt,
  input  logic            flush_req,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic [WB_W-1:0] idex_wb,
  output logic [M_W-1:0]  idex_m,
  output logic [EX_W-1:0] idex_ex,
  output logic            stall_active,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
);

  issue_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic             lu_hit;

  lu_hazard_cmp u_lu_cmp (
    .ex_m       (ex_m),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .lu_hit     (lu_hit)
  );

  // Priority: reset, then redirect flush, then stall, then normal issue.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_wb      = id_wb;
    idex_m       = id_m;
    idex_ex      = id_ex;
    stall_active = 1'b0;
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_wb    = WB_BUBBLE;
      idex_m     = M_BUBBLE;
      idex_ex    = EX_BUBBLE;
    end else if (flush_req) begin
      ifid_flush = 1'b1;
      idex_wb    = WB_BUBBLE;
      idex_m     = M_BUBBLE;
      idex_ex    = EX_BUBBLE;
    end else if (state == ST_LU_STALL || lu_hit) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_wb      = WB_BUBBLE;
      idex_m       = M_BUBBLE;
      idex_ex      = EX_BUBBLE;
      stall_active = 1'b1;
    end
  end

  // The first stall cycle is spent in RUN; LU_STALL covers only the extra ones.
  always_ff @(posedge clk) begin
    if (rst || flush_req) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (lu_hit && (LOAD_EXTRA_STALL > 0)) begin
            state <= ST_LU_STALL;
            cnt   <= CNT_W'(LOAD_EXTRA_STALL);
          end
        end
        ST_LU_STALL: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_active && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_req && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: three instances (extra stall 0, 2, 3) share stimulus
// and are compared against a cycle-level model of remaining stall cycles.
module tb_id_issue_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] id_wb;
  logic [1:0] id_m;
  logic [3:0] id_ex;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [1:0] ex_m;
  logic [4:0] ex_rt;
  logic       flush_req;

  logic        pc_we_o      [3];
  logic        ifid_we_o    [3];
  logic        ifid_flush_o [3];
  logic [1:0]  idex_wb_o    [3];
  logic [1:0]  idex_m_o     [3];
  logic [3:0]  idex_ex_o    [3];
  logic        stall_o      [3];
  logic [31:0] pstall_o     [3];
  logic [31:0] pflush_o     [3];

  int errors = 0;
  int checks = 0;

  // Model state: remaining extra stall cycles and expected perf counts.
  int rem [3];
  int m_stall [3];
  int m_flush [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    id_issue_ctrl #(.LOAD_EXTRA_STALL(L), .CNT_W(4)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .id_wb          (id_wb),
      .id_m           (id_m),
      .id_ex          (id_ex),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_uses_rs     (id_uses_rs),
      .id_uses_rt     (id_uses_rt),
      .ex_m           (ex_m),
      .ex_rt          (ex_rt),
      .flush_req      (flush_req),
      .pc_we          (pc_we_o[g]),
      .ifid_we        (ifid_we_o[g]),
      .ifid_flush     (ifid_flush_o[g]),
      .idex_wb        (idex_wb_o[g]),
      .idex_m         (idex_m_o[g]),
      .idex_ex        (idex_ex_o[g]),
      .stall_active   (stall_o[g]),
      .perf_stall_cnt (pstall_o[g]),
      .perf_flush_cnt (pflush_o[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int les_of(int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  function automatic bit lu_model();
    bit dep;
    dep = (id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt);
    return ex_m[1] && (ex_rt != 0) && dep;
  endfunction

  // Expected {pc_we, ifid_we, ifid_flush, wb, m, ex, stall_active}.
  function automatic logic [11:0] model_out(int r);
    if (rst)               return {3'b001, 8'h00, 1'b0};
    if (flush_req)         return {3'b111, 8'h00, 1'b0};
    if (r > 0 || lu_model()) return {3'b000, 8'h00, 1'b1};
    return {3'b110, id_wb, id_m, id_ex, 1'b0};
  endfunction

  function automatic logic [11:0] got_out(int i);
    return {pc_we_o[i], ifid_we_o[i], ifid_flush_o[i], idex_wb_o[i],
            idex_m_o[i], idex_ex_o[i], stall_o[i]};
  endfunction

  function automatic int exp_perf(int v);
`ifdef ISSUE_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic set_idle();
    id_wb = 0; id_m = 0; id_ex = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_m = 0; ex_rt = 0; flush_req = 0;
  endtask

  // Advance the model over the current cycle's inputs, then take the clock edge.
  task automatic step_model();
    logic [11:0] o;
    bit lu;
    lu = lu_model();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end else begin
        o = model_out(rem[i]);
        if (o[0]) m_stall[i]++;
        if (flush_req) m_flush[i]++;
        if (flush_req)       rem[i] = 0;
        else if (rem[i] > 0) rem[i]--;
        else if (lu)         rem[i] = les_of(i);
        else                 rem[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step_model();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      id_wb = 2'($urandom); id_m = 2'($urandom); id_ex = 4'($urandom);
      id_rs = 5'($urandom); id_rt = 5'($urandom); ex_m = 2'b10; ex_rt = id_rs;
      id_uses_rs = 1; id_uses_rt = 1; flush_req = 1'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_out(i) !== 12'b001_00000000_0) begin
          errors++;
          $display("FAIL reset_outputs dut%0d got=%h exp=%h", i, got_out(i), 12'b001_00000000_0);
        end
      end
      step_model();
    end
    rst = 1'b0;
    set_idle();
    id_ex = 4'b1100; id_wb = 2'b10; id_m = 2'b01;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (idex_ex_o[i] !== 4'b1100 || pc_we_o[i] !== 1'b1 || stall_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_issue dut%0d got ex=%h pc_we=%b exp ex=c pc_we=1", i, idex_ex_o[i], pc_we_o[i]);
      end
      checks++;
      if (pstall_o[i] !== 32'd0 || pflush_o[i] !== 32'd0) begin
        errors++;
        $display("FAIL perf_after_reset dut%0d got=%0d/%0d exp=0/0", i, pstall_o[i], pflush_o[i]);
      end
    end
    step_model();
  endtask

  task automatic test_lu_rs();
    do_reset();
    ex_m = 2'b10; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1; id_m = 2'b11; id_ex = 4'hA;
    #1;
    checks++;
    if (pc_we_o[0] !== 1'b0 || idex_m_o[0] !== 2'b00 || stall_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL lu_rs_stall got pc_we=%b m=%b stall=%b exp 0/00/1", pc_we_o[0], idex_m_o[0], stall_o[0]);
    end
    step_model();
    ex_m = 2'b00;
    #1;
    checks++;
    if (pc_we_o[0] !== 1'b1 || idex_m_o[0] !== 2'b11 || stall_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL lu_rs_resume got pc_we=%b m=%b stall=%b exp 1/11/0", pc_we_o[0], idex_m_o[0], stall_o[0]);
    end
    step_model();
  endtask

  task automatic test_extra_stall();
    do_reset();
    ex_m = 2'b10; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1; id_ex = 4'h5;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (stall_o[1] !== (k < 3)) begin
        errors++;
        $display("FAIL extra_stall_cycle%0d got=%b exp=%b", k, stall_o[1], (k < 3));
      end
      if (k == 3) begin
        checks++;
        if (pc_we_o[1] !== 1'b1 || idex_ex_o[1] !== 4'h5) begin
          errors++;
          $display("FAIL extra_stall_release got pc_we=%b ex=%h exp 1/5", pc_we_o[1], idex_ex_o[1]);
        end
      end
      step_model();
      ex_m = 2'b00;
    end
  endtask

  task automatic test_no_stall();
    for (int c = 0; c < 3; c++) begin
      do_reset();
      case (c)
        0: begin ex_m = 2'b10; ex_rt = 0; id_rs = 0; id_uses_rs = 1; end
        1: begin ex_m = 2'b01; ex_rt = 5'd7; id_rs = 5'd7; id_uses_rs = 1; end
        default: begin ex_m = 2'b10; ex_rt = 5'd12; id_rt = 5'd12; id_uses_rt = 0; end
      endcase
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (stall_o[i] !== 1'b0 || pc_we_o[i] !== 1'b1) begin
          errors++;
          $display("FAIL no_stall_case%0d dut%0d got stall=%b pc_we=%b exp 0/1", c, i, stall_o[i], pc_we_o[i]);
        end
      end
      step_model();
    end
  endtask

  task automatic test_flush_mid_stall();
    do_reset();
    ex_m = 2'b10; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1; id_wb = 2'b11; id_m = 2'b10; id_ex = 4'h9;
    #1;
    checks++;
    if (stall_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_stall got=%b exp=1", stall_o[2]);
    end
    step_model();
    ex_m = 2'b00; flush_req = 1;
    #1;
    checks++;
    if (got_out(2) !== 12'b111_00000000_0) begin
      errors++;
      $display("FAIL flush_mid_stall got=%h exp=%h", got_out(2), 12'b111_00000000_0);
    end
    step_model();
    flush_req = 0;
    #1;
    checks++;
    if (got_out(2) !== {3'b110, 2'b11, 2'b10, 4'h9, 1'b0}) begin
      errors++;
      $display("FAIL flush_resume got=%h exp=%h", got_out(2), {3'b110, 2'b11, 2'b10, 4'h9, 1'b0});
    end
    step_model();
  endtask

  task automatic test_perf();
    do_reset();
    ex_m = 2'b10; ex_rt = 5'd4; id_rt = 5'd4; id_uses_rt = 1;
    step_model();
    ex_m = 2'b00;
    step_model();
    step_model();
    flush_req = 1;
    step_model();
    step_model();
    flush_req = 0;
    checks++;
    if (pstall_o[1] !== 32'(exp_perf(3)) || pflush_o[1] !== 32'(exp_perf(2))) begin
      errors++;
      $display("FAIL perf_counts got=%0d/%0d exp=%0d/%0d", pstall_o[1], pflush_o[1], exp_perf(3), exp_perf(2));
    end
    do_reset();
    checks++;
    if (pstall_o[1] !== 32'd0 || pflush_o[1] !== 32'd0) begin
      errors++;
      $display("FAIL perf_cleared got=%0d/%0d exp=0/0", pstall_o[1], pflush_o[1]);
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 39) == 0);
      flush_req  = ($urandom_range(0, 9) == 0);
      id_wb      = 2'($urandom);
      id_m       = 2'($urandom);
      id_ex      = 4'($urandom);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom);
      id_uses_rt = 1'($urandom);
      ex_m       = 2'($urandom);
      ex_rt      = 5'($urandom_range(0, 3));
      #1;
      for (int i = 0; i < 3; i++) begin
        e = model_out(rem[i]);
        checks++;
        if (got_out(i) !== e) begin
          errors++;
          $display("FAIL random_c%0d dut%0d got=%h exp=%h", c, i, got_out(i), e);
        end
      end
      step_model();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pstall_o[i] !== 32'(exp_perf(m_stall[i])) || pflush_o[i] !== 32'(exp_perf(m_flush[i]))) begin
          errors++;
          $display("FAIL random_perf_c%0d dut%0d got=%0d/%0d exp=%0d/%0d", c, i,
                   pstall_o[i], pflush_o[i], exp_perf(m_stall[i]), exp_perf(m_flush[i]));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
    rst = 1'b1;
    set_idle();
    test_reset();
    test_lu_rs();
    test_extra_stall();
    test_no_stall();
    test_flush_mid_stall();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Issue/hazard controller on the writer side of the ID/EX pipeline register.
- Decides each cycle whether the ID stage's decoded control fields (WB 2b, M 2b, EX 4b) are forwarded into ID/EX or replaced by a bubble.
- Drives PC and IF/ID write-enables for load-use stalls and flush signals for taken-branch redirects.
- Consumes the ID/EX register's M and Rt outputs to detect load-use hazards.

Parameters:
- LOAD_EXTRA_STALL, 0, extra stall cycles after the mandatory 1-cycle load-use stall (slow data memory); range 0..15.
- CNT_W, 4, width of the stall counter; must hold LOAD_EXTRA_STALL.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- id_wb  input  2  decoded WB control from ID
- id_m  input  2  decoded M control from ID; bit1=MemRead, bit0=MemWrite
- id_ex  input  4  decoded EX control from ID
- id_rs  input  5  ID instruction rs field
- id_rt  input  5  ID instruction rt field
- id_uses_rs  input  1  ID instruction reads rs
- id_uses_rt  input  1  ID instruction reads rt
- ex_m  input  2  M field currently held in ID/EX
- ex_rt  input  5  Rt field currently held in ID/EX
- flush_req  input  1  taken branch/jump resolved in EX
- pc_we  output  1  PC write enable
- ifid_we  output  1  IF/ID write enable
- ifid_flush  output  1  IF/ID clear
- idex_wb  output  2  WB control to ID/EX (bubble = 0)
- idex_m  output  2  M control to ID/EX (bubble = 0)
- idex_ex  output  4  EX control to ID/EX (bubble = 0)
- stall_active  output  1  high in every stall cycle

Behaviour:
- Reset: rst, clk, synchronous, active-high.
  - State RUN, counter 0.
  - While rst is high: pc_we=0, ifid_we=0, ifid_flush=1, idex_* = 0, stall_active=0.
- Hazard term: lu_hit = ex_m[1] & (ex_rt != 0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- All outputs are combinational from the current state and inputs, with 0-cycle latency. State updates on posedge clk.
- States:
  - RUN:
    - No hazard and no flush: pc_we=1, ifid_we=1, ifid_flush=0, idex_* = id_*, stall_active=0.
    - lu_hit and no flush: stall cycle (pc_we=0, ifid_we=0, idex_* = 0, stall_active=1). If LOAD_EXTRA_STALL>0, go to LU_STALL with cnt=LOAD_EXTRA_STALL; otherwise stay in RUN.
  - LU_STALL:
    - Stall outputs as above, regardless of lu_hit (ex_m is already a bubble).
    - cnt decrements each cycle. When cnt==1 in this cycle, the next state is RUN.
    - Total stall = 1 + LOAD_EXTRA_STALL cycles.
- flush_req has priority in any state:
  - Outputs: pc_we=1, ifid_we=1, ifid_flush=1, idex_* = 0, stall_active=0.
  - Next state RUN, cnt=0. An in-progress stall is aborted.
- A hazard with ex_rt=0 never stalls.
- A hazard that persists immediately after returning to RUN re-triggers detection normally.
- MemWrite-only instructions in ID/EX (ex_m=2'b01) never cause a stall.

Optional Feature:
- Macro ISSUE_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - Saturating counters, incremented on every stall cycle and every flush cycle respectively.
  - Cleared by rst.
- Undefined: both ports are present and tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - Widths WB_W=2, M_W=2, EX_W=4.
  - M bit indices M_MEMREAD=1, M_MEMWRITE=0.
  - State encoding ST_RUN, ST_LU_STALL.
  - Bubble constants (all-zero WB/M/EX).
- One combinational sub-module, lu_hazard_cmp: computes lu_hit from the ex_m, ex_rt and id_* register fields.
- FSM and output muxing remain in id_issue_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary id_* -> pc_we=0, ifid_we=0, ifid_flush=1, idex_*=0. After release with no hazard -> idex_ex=id_ex (e.g. 4'b1100), pc_we=1.
- Load-use on rs, LOAD_EXTRA_STALL=0: ex_m=2'b10, ex_rt=5'd8, id_rs=5'd8, id_uses_rs=1 -> exactly 1 stall cycle (pc_we=0, idex_m=0). The next cycle (ex_m=0) issues normally.
- LOAD_EXTRA_STALL=2, load-use on rt (id_rt=ex_rt=5'd9) -> stall_active high for exactly 3 consecutive cycles, then pc_we=1.
- No-stall cases:
  - ex_rt=0 with a matching id_rs=0 -> no stall.
  - ex_m=2'b01 (store) with a matching reg -> no stall.
  - id_uses_rt=0 with matching id_rt -> no stall.
- Flush mid-stall, LOAD_EXTRA_STALL=3: assert flush_req in stall cycle 2 -> that cycle ifid_flush=1, pc_we=1, idex_*=0. Next cycle state is RUN and normal issue resumes.
- ISSUE_PERF_EN defined: 1 stall of 3 cycles plus 2 flush cycles -> perf_stall_cnt=3, perf_flush_cnt=2. After rst -> both 0.
